// File: rtl/mux16_rr_sched_if.sv
// Handshake bundle between the round-robin scheduler and its requesters/consumer.
// The master modport is the scheduler side: it drives the mux select and grant status.
interface mux16_rr_sched_if;
    logic        en;
    logic [15:0] req;
    logic        ack;
    logic [3:0]  sel;
    logic        grant_valid;
    logic [15:0] grant_onehot;
    logic        timeout;
    logic        busy;

    modport master (
        input  en, req, ack,
        output sel, grant_valid, grant_onehot, timeout, busy
    );

    modport slave (
        output en, req, ack,
        input  sel, grant_valid, grant_onehot, timeout, busy
    );
endinterface

// File: rtl/mux16_rr_sched.sv
// Round-robin select generator for a 16:1 mux, with hold-until-ack/withdraw/timeout.
// Define MUX16_SCHED_FIXED_PRIO_EN to switch arbitration to fixed priority (index 0 highest).
module mux16_rr_sched #(
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    mux16_rr_sched_if.master bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam bit         TO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  last_q, last_d;
    logic        gv_q, gv_d;
    logic [15:0] oh_q, oh_d;
    logic        to_q, to_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        release_s;
    logic        expire_s;
    logic        grant_s;
    logic [3:0]  base_s;
    logic [4:0]  pick_s;

    // First set bit searching last+1 .. last (mod 16); {found, index}.
    // Scanning from the far end lets the nearest candidate overwrite the others.
    function automatic logic [4:0] arb_pick(input logic [15:0] r, input logic [3:0] last);
        logic [4:0] res;
        logic [3:0] idx;
        res = 5'd0;
        for (int i = 16; i >= 1; i--) begin
            idx = last + 4'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= 4'd0;
            last_q  <= 4'd15;
            gv_q    <= 1'b0;
            oh_q    <= 16'd0;
            to_q    <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            gv_q    <= gv_d;
            oh_q    <= oh_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: release decision (ack > withdraw > expiry) and winner selection.
    always_comb begin
        release_s = 1'b0;
        expire_s  = 1'b0;
        base_s    = last_q;
        case (state_q)
            ST_IDLE: begin
                release_s = 1'b0;
            end
            ST_GRANT: begin
                if (bus.ack) begin
                    release_s = 1'b1;
                end else if (!bus.req[sel_q]) begin
                    release_s = 1'b1;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    release_s = 1'b1;
                    expire_s  = 1'b1;
                end else begin
                    release_s = 1'b0;
                end
                // The pointer update takes effect for the back-to-back search on this edge.
                base_s = release_s ? sel_q : last_q;
            end
            default: begin
                release_s = 1'b0;
            end
        endcase

`ifdef MUX16_SCHED_FIXED_PRIO_EN
        pick_s = arb_pick(bus.req, 4'd15);
`else
        pick_s = arb_pick(bus.req, base_s);
`endif

        grant_s = bus.en && pick_s[4] && ((state_q == ST_IDLE) || release_s);

        if (grant_s) begin
            state_d = ST_GRANT;
        end else if ((state_q == ST_GRANT) && !release_s) begin
            state_d = ST_GRANT;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Output/datapath values loaded on the next edge.
    always_comb begin
        sel_d  = sel_q;
        gv_d   = gv_q;
        oh_d   = oh_q;
        to_d   = expire_s;
        last_d = release_s ? sel_q : last_q;
        if (grant_s) begin
            sel_d = pick_s[3:0];
            gv_d  = 1'b1;
            oh_d  = 16'd1 << pick_s[3:0];
        end else if (state_d == ST_IDLE) begin
            gv_d = 1'b0;
            oh_d = 16'd0;
        end else begin
            gv_d = gv_q;
        end
        if ((state_q == ST_GRANT) && !release_s) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd0;
        end
    end

    assign bus.sel          = sel_q;
    assign bus.grant_valid  = gv_q;
    assign bus.grant_onehot = oh_q;
    assign bus.timeout      = to_q;
    assign bus.busy         = gv_q;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Self-checking bench for mux16_rr_sched: directed table, corner sequences, and
// randomized traffic against a cycle-level reference model of the arbitration rules.
module tb_mux16_rr_sched;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    mux16_rr_sched_if bus();

    mux16_rr_sched #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_last;
    int m_sel;
    int m_held;
    bit m_gv;
    bit m_to;

    typedef struct {
        logic        e;
        logic [15:0] r;
        logic        a;
        logic [3:0]  s;
        logic        gv;
        logic        to;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [15:0] r, input int after);
`ifdef MUX16_SCHED_FIXED_PRIO_EN
        for (int k = 0; k < 16; k++) if (r[k]) return k;
`else
        for (int k = 1; k <= 16; k++) if (r[(after + k) % 16]) return (after + k) % 16;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_last = 15; m_sel = 0; m_held = 0; m_gv = 1'b0; m_to = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic [15:0] r, input logic a);
        bit served, withdrew, expired;
        int p;
        m_to = 1'b0;
        if (!m_gv) begin
            if (e && r != 16'd0) begin
                m_sel = pick(r, m_last); m_gv = 1'b1; m_held = 0;
            end
        end else begin
            served   = a;
            withdrew = !r[m_sel];
            expired  = (TO > 0) && (m_held + 1 >= TO);
            if (served || withdrew || expired) begin
                m_to   = !served && !withdrew;
                m_last = m_sel;
                m_held = 0;
                p = pick(r, m_last);
                if (e && p >= 0) m_sel = p;
                else m_gv = 1'b0;
            end else begin
                m_held++;
            end
        end
    endtask

    function automatic int dut_word();
        return {bus.sel, bus.grant_valid, bus.grant_onehot, bus.timeout, bus.busy};
    endfunction

    function automatic int model_word();
        logic [15:0] oh;
        oh = m_gv ? (16'd1 << m_sel) : 16'd0;
        return {4'(m_sel), m_gv, oh, m_to, m_gv};
    endfunction

    // Apply inputs, clock once, then compare DUT against model and invariant.
    task automatic cycle(input logic e, input logic [15:0] r, input logic a);
        logic [15:0] inv;
        bus.en = e; bus.req = r; bus.ack = a;
        @(posedge clk);
        model_step(e, r, a);
        #1;
        chk("model", dut_word(), model_word());
        inv = bus.grant_valid ? (16'd1 << bus.sel) : 16'd0;
        chk("onehot_inv", int'(bus.grant_onehot), int'(inv));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("reset_out", dut_word(), 0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit fixed;
        logic [15:0] rq;
        logic e, a;
`ifdef MUX16_SCHED_FIXED_PRIO_EN
        fixed = 1'b1;
`else
        fixed = 1'b0;
`endif
        bus.en = 1'b0; bus.req = 16'd0; bus.ack = 1'b0;
        model_reset();
        #2;
        chk("reset_state", dut_word(), 0);
        #1;
        rst = 1'b0;

        // Directed table: idle, single hold+ack, 8421 back-to-back rotation.
        for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 16'h0000, (i == 2), 4'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 16'h0001, 1'b0, 4'd0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 16'h0001, 1'b0, 4'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 16'h0001, 1'b0, 4'd0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 16'h0001, 1'b0, 4'd0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 16'h0000, 1'b1, 4'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 16'h8421, 1'b1, fixed ? 4'd0 : 4'd5,  1'b1, 1'b0};
        tbl[11] = '{1'b1, 16'h8421, 1'b1, fixed ? 4'd0 : 4'd10, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 16'h8421, 1'b1, fixed ? 4'd0 : 4'd15, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 16'h8421, 1'b1, 4'd0, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 16'h8421, 1'b1, fixed ? 4'd0 : 4'd5,  1'b1, 1'b0};
        tbl[15] = '{1'b1, 16'h8421, 1'b1, fixed ? 4'd0 : 4'd10, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 16'h0000, 1'b1, fixed ? 4'd0 : 4'd10, 1'b0, 1'b0};
        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].e, tbl[i].r, tbl[i].a);
            chk($sformatf("tbl%0d", i),
                int'({bus.sel, bus.grant_valid, bus.timeout}),
                int'({tbl[i].s, tbl[i].gv, tbl[i].to}));
        end

        // Timeout: pulse 8 cycles after grant rises, immediate re-grant of sole requester.
        do_reset();
        cycle(1'b1, 16'h0010, 1'b0);
        chk("to_grant", int'({bus.sel, bus.grant_valid}), int'({4'd4, 1'b1}));
        for (int k = 1; k < TO; k++) begin
            cycle(1'b1, 16'h0010, 1'b0);
            chk("to_early", int'(bus.timeout), 0);
        end
        cycle(1'b1, 16'h0010, 1'b0);
        chk("to_pulse", int'({bus.timeout, bus.sel, bus.grant_valid}), int'({1'b1, 4'd4, 1'b1}));
        cycle(1'b1, 16'h0010, 1'b0);
        chk("to_one_cycle", int'(bus.timeout), 0);
        for (int k = 2; k < TO; k++) cycle(1'b1, 16'h0010, 1'b0);
        cycle(1'b1, 16'h0010, 1'b1);
        chk("ack_beats_to", int'({bus.timeout, bus.grant_valid}), int'({1'b0, 1'b1}));
        cycle(1'b1, 16'h0000, 1'b0);
        chk("to_drop", int'(bus.grant_valid), 0);

        // Withdraw hands over to next requester; en low lets current grant finish only.
        do_reset();
        cycle(1'b1, 16'h0108, 1'b0);
        chk("wd_grant3", int'(bus.sel), 3);
        cycle(1'b1, 16'h0100, 1'b0);
        chk("wd_next8", int'({bus.sel, bus.grant_valid, bus.timeout}), int'({4'd8, 1'b1, 1'b0}));
        cycle(1'b0, 16'h0100, 1'b0);
        chk("en0_hold", int'({bus.sel, bus.grant_valid}), int'({4'd8, 1'b1}));
        cycle(1'b0, 16'h0100, 1'b1);
        chk("en0_done", int'(bus.grant_valid), 0);
        cycle(1'b0, 16'h0100, 1'b0);
        chk("en0_idle", int'(bus.grant_valid), 0);

        // Asynchronous reset mid-grant, then first grant restarts at index 0.
        do_reset();
        cycle(1'b1, 16'h0200, 1'b0);
        chk("rst_pre9", int'({bus.sel, bus.grant_valid}), int'({4'd9, 1'b1}));
        do_reset();
        cycle(1'b1, 16'hFFFF, 1'b0);
        chk("rst_first0", int'({bus.sel, bus.grant_valid}), int'({4'd0, 1'b1}));

        // Randomized traffic: sticky requests, sparse acks, occasional en drop.
        do_reset();
        rq = 16'h0000;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) rq = 16'($urandom) & 16'($urandom);
            e = ($urandom_range(0, 9) != 0);
            a = ($urandom_range(0, 5) == 0);
            cycle(e, rq, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
